// File: rtl/fpu_norm_shift_pkg.sv
// ----------------------------------------------------------------------------
// fpu_norm_shift_pkg : shared widths and result-class code for the FPU
//                      normalization stage.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fpu_norm_shift_pkg;
  localparam int MANT_W    = 32;
  localparam int EXP_W     = 10;
  localparam int OUT_EXP_W = 8;
  localparam int EXP_MAX   = 255;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    ZERO   = 2'd1,
    UFLOW  = 2'd2,
    OFLOW  = 2'd3
  } norm_class_e;
endpackage

`default_nettype wire

// File: rtl/fpu_norm_barrel_shl.sv
// ----------------------------------------------------------------------------
// fpu_norm_barrel_shl : combinational logarithmic left shifter.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fpu_norm_barrel_shl #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic [WIDTH-1:0] data_o
);

  logic [SHW:0][WIDTH-1:0] stage_w;

  assign stage_w[0] = data_i;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    assign stage_w[k+1] = shamt_i[k] ? (stage_w[k] << (1 << k)) : stage_w[k];
  end

  assign data_o = stage_w[SHW];

endmodule

`default_nettype wire

// File: rtl/fpu_norm_shift.sv
// ----------------------------------------------------------------------------
// fpu_norm_shift : two-stage normalize/classify stage with valid/ready flow.
// Define FPU_NORM_DENORM_EN to emit denormals instead of flushing underflow.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fpu_norm_shift #(
  parameter int MANT_W    = fpu_norm_shift_pkg::MANT_W,
  parameter int EXP_W     = fpu_norm_shift_pkg::EXP_W,
  parameter int OUT_EXP_W = fpu_norm_shift_pkg::OUT_EXP_W
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic [EXP_W-1:0]           in_exp,
  input  logic [MANT_W-1:0]          in_mant,
  input  logic [$clog2(MANT_W)-1:0]  in_lzd_pos,
  input  logic                       in_lzd_valid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sign,
  output logic [OUT_EXP_W-1:0]       out_exp,
  output logic [MANT_W-1:0]          out_mant,
  output logic                       out_zero,
  output logic                       out_uflow,
  output logic                       out_oflow
);
  import fpu_norm_shift_pkg::*;

  localparam int LZD_W = $clog2(MANT_W);
  localparam logic signed [EXP_W:0] EXP_HI  = (EXP_W+1)'(EXP_MAX);
  localparam logic signed [EXP_W:0] EXP_NIL = '0;

  logic signed [EXP_W:0] exp_in_w;
  logic signed [EXP_W:0] exp_tmp_w;
  norm_class_e           cls_w;
  logic [LZD_W-1:0]      shamt_w;
  logic                  s1_adv_w;
  logic                  s2_adv_w;
  logic [MANT_W-1:0]     shl_w;

  logic                  s1_valid_q, s1_sign_q;
  logic [MANT_W-1:0]     s1_mant_q;
  logic [LZD_W-1:0]      s1_shamt_q;
  logic [OUT_EXP_W-1:0]  s1_exp_q;
  norm_class_e           s1_cls_q;

  logic                  s2_valid_q, s2_sign_q;
  logic [OUT_EXP_W-1:0]  s2_exp_q, s2_exp_d;
  logic [MANT_W-1:0]     s2_mant_q, s2_mant_d;
  logic                  s2_zero_q, s2_zero_d;
  logic                  s2_uflow_q, s2_uflow_d;
  logic                  s2_oflow_q, s2_oflow_d;

  assign s2_adv_w = !s2_valid_q || out_ready;
  assign s1_adv_w = !s1_valid_q || s2_adv_w;
  assign in_ready = s1_adv_w;

  // Exponent after normalization, one bit wider so the subtraction cannot wrap.
  assign exp_in_w  = {in_exp[EXP_W-1], in_exp};
  assign exp_tmp_w = exp_in_w - {{(EXP_W+1-LZD_W){1'b0}}, in_lzd_pos};

  always_comb begin
    if (!in_lzd_valid)            cls_w = ZERO;
    else if (exp_tmp_w >= EXP_HI) cls_w = OFLOW;
    else if (exp_tmp_w <= EXP_NIL) cls_w = UFLOW;
    else                          cls_w = NORMAL;
  end

  always_comb begin
    shamt_w = in_lzd_pos;
`ifdef FPU_NORM_DENORM_EN
    // Underflow implies in_exp <= lzd_pos, so in_exp-1 always fits and loses no bits.
    if (cls_w == UFLOW)
      shamt_w = (exp_in_w > EXP_NIL) ? (in_exp[LZD_W-1:0] - LZD_W'(1)) : '0;
`endif
  end

  fpu_norm_barrel_shl #(
    .WIDTH (MANT_W),
    .SHW   (LZD_W)
  ) u_shl (
    .data_i  (s1_mant_q),
    .shamt_i (s1_shamt_q),
    .data_o  (shl_w)
  );

  always_comb begin
    s2_mant_d  = '0;
    s2_exp_d   = '0;
    s2_zero_d  = 1'b0;
    s2_uflow_d = 1'b0;
    s2_oflow_d = 1'b0;
    case (s1_cls_q)
      NORMAL: begin
        s2_mant_d = shl_w;
        s2_exp_d  = s1_exp_q;
      end
      ZERO: s2_zero_d = 1'b1;
      OFLOW: begin
        s2_exp_d   = OUT_EXP_W'(EXP_MAX);
        s2_oflow_d = 1'b1;
      end
      UFLOW: begin
        s2_uflow_d = 1'b1;
`ifdef FPU_NORM_DENORM_EN
        s2_mant_d  = shl_w;
`else
        s2_zero_d  = 1'b1;
`endif
      end
      default: s2_mant_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mant_q  <= '0;
      s1_shamt_q <= '0;
      s1_exp_q   <= '0;
      s1_cls_q   <= NORMAL;
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_mant_q  <= '0;
      s2_zero_q  <= 1'b0;
      s2_uflow_q <= 1'b0;
      s2_oflow_q <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
      end else begin
        if (s1_adv_w) s1_valid_q <= in_valid;
        if (s2_adv_w) s2_valid_q <= s1_valid_q;
      end
      if (s1_adv_w && in_valid) begin
        s1_sign_q  <= in_sign;
        s1_mant_q  <= in_mant;
        s1_shamt_q <= shamt_w;
        s1_exp_q   <= exp_tmp_w[OUT_EXP_W-1:0];
        s1_cls_q   <= cls_w;
      end
      if (s2_adv_w && s1_valid_q) begin
        s2_sign_q  <= s1_sign_q;
        s2_exp_q   <= s2_exp_d;
        s2_mant_q  <= s2_mant_d;
        s2_zero_q  <= s2_zero_d;
        s2_uflow_q <= s2_uflow_d;
        s2_oflow_q <= s2_oflow_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sign  = s2_sign_q;
  assign out_exp   = s2_exp_q;
  assign out_mant  = s2_mant_q;
  assign out_zero  = s2_zero_q;
  assign out_uflow = s2_uflow_q;
  assign out_oflow = s2_oflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_norm_shift.sv
// ----------------------------------------------------------------------------
// tb_fpu_norm_shift : randomized and directed bench with a scoreboard model.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fpu_norm_shift;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [31:0] in_mant;
  logic [4:0]  in_lzd_pos;
  logic        in_lzd_valid;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [31:0] out_mant;
  logic        out_zero, out_uflow, out_oflow;

  int n_chk  = 0;
  int n_fail = 0;

  logic [43:0] exp_q[$];
  logic [43:0] pend;

  fpu_norm_shift dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .in_lzd_pos   (in_lzd_pos),
    .in_lzd_valid (in_lzd_valid),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign     (out_sign),
    .out_exp      (out_exp),
    .out_mant     (out_mant),
    .out_zero     (out_zero),
    .out_uflow    (out_uflow),
    .out_oflow    (out_oflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [43:0] pack(input bit s, input logic [7:0] e, input logic [31:0] m,
                                       input bit z, input bit u, input bit o);
    return {s, e, m, z, u, o};
  endfunction

  function automatic logic [43:0] out_word();
    return {out_sign, out_exp, out_mant, out_zero, out_uflow, out_oflow};
  endfunction

  // Reference: plain integer arithmetic on the classification rules.
  function automatic logic [43:0] model(input bit s, input logic [9:0] e, input logic [31:0] m,
                                        input logic [4:0] lz, input bit lv);
    int ei, et, sh;
    ei = int'($signed(e));
    et = ei - int'(lz);
    sh = 0;
    if (!lv)       return pack(s, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    if (et >= 255) return pack(s, 8'd255, 32'd0, 1'b0, 1'b0, 1'b1);
    if (et <= 0) begin
`ifdef FPU_NORM_DENORM_EN
      sh = (ei >= 1) ? ei - 1 : 0;
      return pack(s, 8'd0, m << sh, 1'b0, 1'b1, 1'b0);
`else
      return pack(s, 8'd0, 32'd0, 1'b1, 1'b1, 1'b0);
`endif
    end
    return pack(s, et[7:0], m << lz, 1'b0, 1'b0, 1'b0);
  endfunction

  // Called at a negedge after inputs are driven; ends at the next negedge.
  task automatic step(output bit acc);
    #1;
    acc = 1'b0;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        check(out_ready ? "deliver" : "hold_stable", 64'(out_word()), 64'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (flush) exp_q.delete();
    else if (in_valid && in_ready) begin
      exp_q.push_back(pend);
      acc = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit s, input logic [9:0] e, input logic [31:0] m,
                       input logic [4:0] lz, input bit lv, input bit ordy, input bit fl,
                       input logic [43:0] want, output bit acc);
    in_valid = v; in_sign = s; in_exp = e; in_mant = m;
    in_lzd_pos = lz; in_lzd_valid = lv; out_ready = ordy; flush = fl;
    pend = want;
    step(acc);
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, ordy, 1'b0, '0, acc);
  endtask

  task automatic send(input bit s, input logic [9:0] e, input logic [31:0] m,
                      input logic [4:0] lz, input bit lv, input logic [43:0] want);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      drive(1'b1, s, e, m, lz, lv, 1'b1, 1'b0, want, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      idle(1'b1);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_beat(output bit s, output logic [9:0] e, output logic [31:0] m,
                           output logic [4:0] lz, output bit lv);
    logic [31:0] lead;
    int p;
    s  = 1'($urandom());
    lv = ($urandom_range(0, 9) != 0);
    if (lv) begin
      p    = $urandom_range(0, 31);
      lead = 32'h8000_0000 >> p;
      m    = lead | ($urandom() & (lead - 32'd1));
      lz   = 5'(p);
    end else begin
      m  = '0;
      lz = 5'($urandom());
    end
    case ($urandom_range(0, 3))
      0:       e = 10'($urandom());
      1:       e = 10'($urandom_range(240, 290));
      2:       e = 10'($urandom_range(0, 40));
      default: e = 10'($urandom_range(40, 240));
    endcase
  endtask

  initial begin
    bit acc, s, lv;
    logic [9:0]  e;
    logic [31:0] m;
    logic [4:0]  lz;
    int idx, cyc;

    rst_l = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0;
    in_mant = '0; in_lzd_pos = '0; in_lzd_valid = 1'b0; out_ready = 1'b0; pend = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_word()), 64'd0);
    rst_l = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Directed cases, expectations worked by hand.
    send(1'b0, 10'd130, 32'h0000_8000, 5'd16, 1'b1, pack(1'b0, 8'd114, 32'h8000_0000, 1'b0, 1'b0, 1'b0));
    send(1'b1, 10'd200, 32'h0,         5'd0,  1'b0, pack(1'b1, 8'd0,   32'h0,         1'b1, 1'b0, 1'b0));
    send(1'b0, 10'd300, 32'h8000_0000, 5'd0,  1'b1, pack(1'b0, 8'd255, 32'h0,         1'b0, 1'b0, 1'b1));
    send(1'b1, 10'd255, 32'h8000_0000, 5'd0,  1'b1, pack(1'b1, 8'd255, 32'h0,         1'b0, 1'b0, 1'b1));
    send(1'b0, 10'd254, 32'h8000_0001, 5'd0,  1'b1, pack(1'b0, 8'd254, 32'h8000_0001, 1'b0, 1'b0, 1'b0));
    send(1'b0, 10'd32,  32'h0000_0001, 5'd31, 1'b1, pack(1'b0, 8'd1,   32'h8000_0000, 1'b0, 1'b0, 1'b0));
`ifdef FPU_NORM_DENORM_EN
    send(1'b0, 10'd5,   32'h00C0_0000, 5'd8,  1'b1, pack(1'b0, 8'd0, 32'h0C00_0000, 1'b0, 1'b1, 1'b0));
    send(1'b1, 10'd3,   32'h1000_0000, 5'd3,  1'b1, pack(1'b1, 8'd0, 32'h4000_0000, 1'b0, 1'b1, 1'b0));
    send(1'b0, 10'h3FD, 32'h2000_0000, 5'd2,  1'b1, pack(1'b0, 8'd0, 32'h2000_0000, 1'b0, 1'b1, 1'b0));
`else
    send(1'b0, 10'd5,   32'h00C0_0000, 5'd8,  1'b1, pack(1'b0, 8'd0, 32'h0,         1'b1, 1'b1, 1'b0));
    send(1'b1, 10'd3,   32'h1000_0000, 5'd3,  1'b1, pack(1'b1, 8'd0, 32'h0,         1'b1, 1'b1, 1'b0));
    send(1'b0, 10'h3FD, 32'h2000_0000, 5'd2,  1'b1, pack(1'b0, 8'd0, 32'h0,         1'b1, 1'b1, 1'b0));
`endif
    drain();

    // Six back-to-back beats against a 1,0,0 ready pattern.
    idx = 0;
    cyc = 0;
    rand_beat(s, e, m, lz, lv);
    while ((idx < 6 || exp_q.size() != 0) && cyc < 60) begin
      if (idx < 6) begin
        drive(1'b1, s, e, m, lz, lv, (cyc % 3) == 0, 1'b0, model(s, e, m, lz, lv), acc);
        if (acc) begin
          idx++;
          rand_beat(s, e, m, lz, lv);
        end
      end else begin
        idle((cyc % 3) == 0);
      end
      cyc++;
    end
    check("bp_all_delivered", 64'(exp_q.size()), 64'd0);

    // Flush with two beats in flight; the flush-cycle beat is dropped too.
    rand_beat(s, e, m, lz, lv);
    drive(1'b1, s, e, m, lz, lv, 1'b0, 1'b0, model(s, e, m, lz, lv), acc);
    rand_beat(s, e, m, lz, lv);
    drive(1'b1, s, e, m, lz, lv, 1'b0, 1'b0, model(s, e, m, lz, lv), acc);
    check("flush_pre_valid", 64'(out_valid), 64'd1);
    rand_beat(s, e, m, lz, lv);
    drive(1'b1, s, e, m, lz, lv, 1'b0, 1'b1, model(s, e, m, lz, lv), acc);
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("flush_no_valid", 64'(out_valid), 64'd0);
      idle(1'b1);
    end

    // Random stream with random backpressure.
    rand_beat(s, e, m, lz, lv);
    for (int k = 0; k < 400; k++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      drive(v, s, e, m, lz, lv, $urandom_range(0, 9) < 7, 1'b0, model(s, e, m, lz, lv), acc);
      if (acc) rand_beat(s, e, m, lz, lv);
    end
    drain();

    // Asynchronous reset with beats in flight.
    for (int k = 0; k < 3; k++) begin
      rand_beat(s, e, m, lz, lv);
      drive(1'b1, s, e, m, lz, lv, 1'b0, 1'b0, model(s, e, m, lz, lv), acc);
    end
    check("arst_pre_valid", 64'(out_valid), 64'd1);
    #3;
    rst_l = 1'b0;
    #1;
    check("arst_valid_drop", 64'(out_valid), 64'd0);
    check("arst_data_clear", 64'(out_word()), 64'd0);
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    send(1'b0, 10'd130, 32'h0000_8000, 5'd16, 1'b1, pack(1'b0, 8'd114, 32'h8000_0000, 1'b0, 1'b0, 1'b0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
